// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bus: decode-stage fields in, registered execute controls out.
interface id_ex_stage_if;
    localparam int unsigned XLEN = 32;
    localparam int unsigned REGW = 5;
    localparam int unsigned OPW  = 6;
    localparam int unsigned ALUW = 3;

    logic            stall;
    logic            flush;
    logic            in_valid;
    logic [OPW-1:0]  opcode;
    logic [OPW-1:0]  funct;
    logic [REGW-1:0] instr_shamt;
    logic [REGW-1:0] rt;
    logic [REGW-1:0] rd;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] signimm;

    logic [XLEN-1:0] srca;
    logic [XLEN-1:0] srcb;
    logic [REGW-1:0] shamt;
    logic [ALUW-1:0] alucontrol;
    logic            valid;
    logic            regwrite;
    logic            memtoreg;
    logic            memwrite;
    logic            branch;
    logic            bne;
    logic [REGW-1:0] writereg;
    logic            illegal;

    modport master (
        output stall, flush, in_valid, opcode, funct, instr_shamt, rt, rd, rd1, rd2, signimm,
        input  srca, srcb, shamt, alucontrol, valid, regwrite, memtoreg, memwrite, branch, bne,
               writereg, illegal
    );

    modport slave (
        input  stall, flush, in_valid, opcode, funct, instr_shamt, rt, rd, rd1, rd2, signimm,
        output srca, srcb, shamt, alucontrol, valid, regwrite, memtoreg, memwrite, branch, bne,
               writereg, illegal
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with main/ALU decode; every output is a flop.
module id_ex_stage (
    input  logic          clk,
    input  logic          reset,
    id_ex_stage_if.slave  bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned REGW = 5;
    localparam int unsigned OPW  = 6;
    localparam int unsigned ALUW = 3;

    localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPW-1:0] OP_LW    = 6'b100011;
    localparam logic [OPW-1:0] OP_SW    = 6'b101011;
    localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPW-1:0] OP_BNE   = 6'b000101;
    localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;

    localparam logic [OPW-1:0] FN_ADD = 6'b100000;
    localparam logic [OPW-1:0] FN_SUB = 6'b100010;
    localparam logic [OPW-1:0] FN_AND = 6'b100100;
    localparam logic [OPW-1:0] FN_OR  = 6'b100101;
    localparam logic [OPW-1:0] FN_SLT = 6'b101010;
    localparam logic [OPW-1:0] FN_SLL = 6'b000000;

    localparam logic [ALUW-1:0] ALU_ADD = 3'b010;
    localparam logic [ALUW-1:0] ALU_SUB = 3'b110;
    localparam logic [ALUW-1:0] ALU_AND = 3'b000;
    localparam logic [ALUW-1:0] ALU_OR  = 3'b001;
    localparam logic [ALUW-1:0] ALU_SLT = 3'b111;
    localparam logic [ALUW-1:0] ALU_SLL = 3'b011;

    // Decode results
    logic            d_legal;
    logic [ALUW-1:0] d_alu;
    logic            d_use_imm;
    logic            d_regwrite;
    logic            d_memtoreg;
    logic            d_memwrite;
    logic            d_branch;
    logic            d_bne;
    logic            d_dst_rd;
    logic            d_dst_rt;
    logic            d_sll;

    // Next register values
    logic [XLEN-1:0] n_srca;
    logic [XLEN-1:0] n_srcb;
    logic [REGW-1:0] n_shamt;
    logic [ALUW-1:0] n_alucontrol;
    logic            n_valid;
    logic            n_regwrite;
    logic            n_memtoreg;
    logic            n_memwrite;
    logic            n_branch;
    logic            n_bne;
    logic [REGW-1:0] n_writereg;
    logic            n_illegal;

    // Main decoder plus R-type funct decoder
    always_comb begin
        d_legal    = 1'b0;
        d_alu      = ALU_ADD;
        d_use_imm  = 1'b0;
        d_regwrite = 1'b0;
        d_memtoreg = 1'b0;
        d_memwrite = 1'b0;
        d_branch   = 1'b0;
        d_bne      = 1'b0;
        d_dst_rd   = 1'b0;
        d_dst_rt   = 1'b0;
        d_sll      = 1'b0;
        unique case (bus.opcode)
            OP_RTYPE: begin
                d_regwrite = 1'b1;
                d_dst_rd   = 1'b1;
                d_legal    = 1'b1;
                unique case (bus.funct)
                    FN_ADD:  d_alu = ALU_ADD;
                    FN_SUB:  d_alu = ALU_SUB;
                    FN_AND:  d_alu = ALU_AND;
                    FN_OR:   d_alu = ALU_OR;
                    FN_SLT:  d_alu = ALU_SLT;
                    FN_SLL: begin
                        d_alu = ALU_SLL;
                        d_sll = 1'b1;
                    end
                    default: d_legal = 1'b0;
                endcase
            end
            OP_LW: begin
                d_legal    = 1'b1;
                d_use_imm  = 1'b1;
                d_regwrite = 1'b1;
                d_memtoreg = 1'b1;
                d_dst_rt   = 1'b1;
            end
            OP_SW: begin
                d_legal    = 1'b1;
                d_use_imm  = 1'b1;
                d_memwrite = 1'b1;
            end
            OP_BEQ: begin
                d_legal  = 1'b1;
                d_alu    = ALU_SUB;
                d_branch = 1'b1;
            end
            OP_BNE: begin
                d_legal = 1'b1;
                d_alu   = ALU_SUB;
                d_bne   = 1'b1;
            end
            OP_ADDI: begin
                d_legal    = 1'b1;
                d_use_imm  = 1'b1;
                d_regwrite = 1'b1;
                d_dst_rt   = 1'b1;
            end
            default: d_legal = 1'b0;
        endcase
    end

    // Value to load when the stage advances: bubble unless a valid legal instruction arrives
    always_comb begin
        n_srca       = '0;
        n_srcb       = '0;
        n_shamt      = '0;
        n_alucontrol = ALU_ADD;
        n_valid      = 1'b0;
        n_regwrite   = 1'b0;
        n_memtoreg   = 1'b0;
        n_memwrite   = 1'b0;
        n_branch     = 1'b0;
        n_bne        = 1'b0;
        n_writereg   = '0;
        n_illegal    = 1'b0;
        if (!bus.flush && bus.in_valid) begin
            if (!d_legal) begin
                n_illegal = 1'b1;
            end else begin
                n_valid      = 1'b1;
                n_srca       = bus.rd1;
                n_srcb       = d_use_imm ? bus.signimm : bus.rd2;
                n_shamt      = d_sll ? bus.instr_shamt : REGW'(0);
                n_alucontrol = d_alu;
                n_regwrite   = d_regwrite;
                n_memtoreg   = d_memtoreg;
                n_memwrite   = d_memwrite;
                n_branch     = d_branch;
                n_bne        = d_bne;
                n_writereg   = d_dst_rd ? bus.rd : (d_dst_rt ? bus.rt : REGW'(0));
            end
        end
    end

    // Pipeline register: flush overrides stall, stall holds everything
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.srca       <= '0;
            bus.srcb       <= '0;
            bus.shamt      <= '0;
            bus.alucontrol <= ALU_ADD;
            bus.valid      <= 1'b0;
            bus.regwrite   <= 1'b0;
            bus.memtoreg   <= 1'b0;
            bus.memwrite   <= 1'b0;
            bus.branch     <= 1'b0;
            bus.bne        <= 1'b0;
            bus.writereg   <= '0;
            bus.illegal    <= 1'b0;
        end else if (bus.flush || !bus.stall) begin
            bus.srca       <= n_srca;
            bus.srcb       <= n_srcb;
            bus.shamt      <= n_shamt;
            bus.alucontrol <= n_alucontrol;
            bus.valid      <= n_valid;
            bus.regwrite   <= n_regwrite;
            bus.memtoreg   <= n_memtoreg;
            bus.memwrite   <= n_memwrite;
            bus.branch     <= n_branch;
            bus.bne        <= n_bne;
            bus.writereg   <= n_writereg;
            bus.illegal    <= n_illegal;
        end
    end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; reset  in  1  asynchronous, active-low reset.
REQ-002 SHALL have inputs: stall 1 (hold stage); flush 1 (insert bubble); in_valid 1 (decode-stage instruction valid); opcode 6; funct 6; instr_shamt 5; rt 5; rd 5; rd1 32; rd2 32; signimm 32.
REQ-003 SHALL have registered ALU-side outputs: srca 32; srcb 32; shamt 5; alucontrol 3.
REQ-004 SHALL have registered pipeline outputs: valid 1; regwrite 1; memtoreg 1; memwrite 1; branch 1 (beq); bne 1; writereg 5; illegal 1 (unsupported instruction seen).

Function
REQ-005 SHALL decode opcode/funct combinationally and capture all outputs on the rising clk edge; latency exactly 1 cycle from decode inputs to outputs.
REQ-006 SHALL use alucontrol codes: add 010, sub 110, and 000, or 001, slt 111, sll 011.
REQ-007 SHALL decode R-type (opcode 000000) by funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 000000 sll; srca=rd1, srcb=rd2, regwrite=1, writereg=rd.
REQ-008 SHALL set shamt=instr_shamt for sll only; shamt=0 for all other operations.
REQ-009 SHALL decode lw (100011): add, srcb=signimm, regwrite=1, memtoreg=1, writereg=rt.
REQ-010 SHALL decode sw (101011): add, srcb=signimm, memwrite=1, regwrite=0, writereg=0.
REQ-011 SHALL decode beq (000100): sub, srcb=rd2, branch=1; bne (000101): sub, srcb=rd2, bne=1; both regwrite=0, writereg=0.
REQ-012 SHALL decode addi (001000): add, srcb=signimm, regwrite=1, writereg=rt.
REQ-013 SHALL treat any other opcode, or R-type with other funct, as illegal: load a bubble and set illegal=1 for that cycle.
REQ-014 Bubble SHALL mean valid=0, regwrite=memtoreg=memwrite=branch=bne=0, writereg=0, srca=srcb=0, shamt=0, alucontrol=010.
REQ-015 SHALL apply per-edge priority: reset > flush > stall > load.
REQ-016 flush=1 SHALL load a bubble with illegal=0, regardless of stall or in_valid.
REQ-017 stall=1 with flush=0 SHALL hold every output, illegal included, unchanged.
REQ-018 Load with in_valid=0 SHALL load a bubble with illegal=0; decode of opcode/funct SHALL be ignored.
REQ-019 Load with in_valid=1 and a legal instruction SHALL set valid=1, illegal=0 and decoded fields.
REQ-020 illegal SHALL clear on the next load or flush; it SHALL NOT be sticky.
REQ-021 No output SHALL depend combinationally on any input; all are flop outputs.

Reset
REQ-022 reset=0 SHALL immediately, without waiting for clk, force the bubble state of REQ-014 and illegal=0.
REQ-023 While reset=0, SHALL ignore stall, flush and in_valid; first load occurs on the first rising clk with reset=1.
REQ-024 Reset asserted mid-stall SHALL discard the held instruction; after release, outputs remain bubble until a load.

Verification
REQ-025 Reset: reset=0 between edges with valid=1 held -> valid=0, regwrite=0, alucontrol=010 before the next edge.
REQ-026 R-type sll: in_valid=1, opcode=000000, funct=000000, instr_shamt=4, rd=9, rd2=0x00000003 -> next cycle alucontrol=011, shamt=4, srcb=0x00000003, regwrite=1, writereg=9.
REQ-027 lw then stall: lw with rt=5, signimm=0x00000010, rd1=0x100 captured; stall=1 for 3 cycles while inputs change to sub -> outputs stay alucontrol=010, srcb=0x10, memtoreg=1, writereg=5.
REQ-028 Flush vs stall: stall=1 and flush=1 on the same edge with valid addi held -> valid=0, regwrite=0, illegal=0.
REQ-029 Illegal: opcode=111111, in_valid=1 -> valid=0, illegal=1 for one cycle; next edge legal beq -> illegal=0, branch=1, alucontrol=110.
REQ-030 Invalid input: in_valid=0 with opcode=100011 -> bubble, memtoreg=0, illegal=0.
